// File: rtl/dm_bus_master_pkg.sv
// Shared encodings for the data-memory bus master: access kinds, FSM states and bus widths.
package dm_bus_master_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned BeW   = 4;

    localparam logic [2:0] OpW  = 3'd0;
    localparam logic [2:0] OpH  = 3'd1;
    localparam logic [2:0] OpHu = 3'd2;
    localparam logic [2:0] OpB  = 3'd3;
    localparam logic [2:0] OpBu = 3'd4;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StResp,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/dm_bus_master_if.sv
// Request/grant/response data-memory bus; master drives the command, slave answers.
interface dm_bus_master_if;
    import dm_bus_master_pkg::*;

    logic             bus_req;
    logic             bus_we;
    logic [DataW-1:0] bus_addr;
    logic [BeW-1:0]   bus_be;
    logic [DataW-1:0] bus_wdata;
    logic             bus_gnt;
    logic             bus_rvalid;
    logic [DataW-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );

endinterface

// File: rtl/dm_lane_align.sv
// Little-endian lane steering: store byte enables and lane replication, load extraction
// and extension, plus the legality check for an access.
module dm_lane_align
    import dm_bus_master_pkg::*;
(
    input  logic [2:0]       op,
    input  logic             we,
    input  logic [1:0]       laddr,
    input  logic [DataW-1:0] wdata,
    input  logic [DataW-1:0] rdata,
    output logic [BeW-1:0]   be,
    output logic [DataW-1:0] wdata_rep,
    output logic [DataW-1:0] rdata_ext,
    output logic             misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = 8'(rdata >> {laddr, 3'b000});
        half_sel  = laddr[1] ? rdata[31:16] : rdata[15:0];
        be        = '0;
        wdata_rep = wdata;
        rdata_ext = rdata;
        misalign  = 1'b0;
        // misalign also flags unencodable ops and unsigned stores
        case (op)
            OpW: begin
                be       = 4'b1111;
                misalign = (laddr != 2'b00);
            end
            OpH, OpHu: begin
                be        = laddr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = (op == OpH) ? {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
                misalign  = laddr[0] | (we & (op == OpHu));
            end
            OpB, OpBu: begin
                be        = 4'b0001 << laddr;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = (op == OpB) ? {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
                misalign  = we & (op == OpBu);
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/dm_bus_master.sv
// MEM-stage initiator: turns a CPU load/store into one bus command, stalls the pipeline
// until the response, a fault or a timeout, and extends returned load data.
module dm_bus_master
    import dm_bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [2:0]       cpu_op,
    input  logic [DataW-1:0] cpu_addr,
    input  logic [DataW-1:0] cpu_wdata,
    output logic             cpu_stall,
    output logic             cpu_done,
    output logic             cpu_err,
    output logic [DataW-1:0] cpu_rdata,
    dm_bus_master_if.master  bus
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [DataW-1:0] addr_q, wdata_q, rdata_q;
    logic [BeW-1:0]   be_q;
    logic             we_q;
    logic [2:0]       op_q;
    logic [1:0]       laddr_q;

    logic             load_cmd, cap_rdata, timeout;
    logic [2:0]       op_sel;
    logic [1:0]       laddr_sel;
    logic [BeW-1:0]   be;
    logic [DataW-1:0] wdata_rep, rdata_ext;
    logic             misalign;

    // IDLE encodes the live CPU operands; afterwards the latched op steers the response
    assign op_sel    = (state_q == StIdle) ? cpu_op : op_q;
    assign laddr_sel = (state_q == StIdle) ? cpu_addr[1:0] : laddr_q;

    dm_lane_align u_lane_align (
        .op        (op_sel),
        .we        (cpu_we),
        .laddr     (laddr_sel),
        .wdata     (cpu_wdata),
        .rdata     (bus.bus_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext),
        .misalign  (misalign)
    );

    always_comb begin
        state_d   = state_q;
        load_cmd  = 1'b0;
        cap_rdata = 1'b0;
        timeout   = (cnt_q == TimeoutLast);
        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    state_d  = misalign ? StErr : StReq;
                    load_cmd = ~misalign;
                end
            end
            StReq: begin
                if (timeout)          state_d = StErr;
                else if (bus.bus_gnt) state_d = StResp;
            end
            StResp: begin
                // a response arriving on the timeout cycle still completes the access
                if (bus.bus_rvalid) begin
                    state_d   = StDone;
                    cap_rdata = ~we_q;
                end else if (timeout) begin
                    state_d = StErr;
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (load_cmd)                                  cnt_d = '0;
        else if (state_q == StReq || state_q == StResp) cnt_d = cnt_q + 8'd1;
        else                                           cnt_d = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            op_q    <= OpW;
            laddr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_cmd) begin
                addr_q  <= {cpu_addr[DataW-1:2], 2'b00};
                wdata_q <= wdata_rep;
                be_q    <= be;
                we_q    <= cpu_we;
                op_q    <= cpu_op;
                laddr_q <= cpu_addr[1:0];
            end
            if (cap_rdata) rdata_q <= rdata_ext;
        end
    end

    assign cpu_stall     = cpu_req & ~(state_q == StDone || state_q == StErr);
    assign cpu_done      = (state_q == StDone) || (state_q == StErr);
    assign cpu_err       = (state_q == StErr);
    assign cpu_rdata     = rdata_q;
    assign bus.bus_req   = (state_q == StReq);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

endmodule

// File: doc/dm_bus_master.md
# dm_bus_master

CPU-side initiator that carries MEM-stage loads and stores to a data memory over a request/grant/response bus with wait states. It replaces the single-cycle combinational memory path.
- Stores: generates byte enables and replicated write lanes.
- Loads: zero/sign-extends the returned word.
- Holds the pipeline via `cpu_stall` until the bus transaction completes, faults, or times out.

## Interface
- `TIMEOUT`, default 64 — max cycles in REQ+RESP before abort; legal range 2..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `cpu_req`  in  1  MEM stage holds a valid memory op; stays high with stable operands until `cpu_done`.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_op`  in  3  access kind: W=0, H=1, HU=2, B=3, BU=4.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  store data, right-justified.
- `cpu_stall`  out  1  hold pipeline.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  valid with `cpu_done`: misaligned access, illegal op, or timeout.
- `cpu_rdata`  out  32  extended load data; valid with `cpu_done`.
- `bus_req`  out  1  address/command valid.
- `bus_we`  out  1  write command.
- `bus_addr`  out  32  word address; `cpu_addr` with [1:0] forced to 0.
- `bus_be`  out  4  byte enables; bit k covers data[8k+7:8k].
- `bus_wdata`  out  32  lane-replicated write data.
- `bus_gnt`  in  1  command accepted in a cycle where `bus_req` is high.
- `bus_rvalid`  in  1  response; write ack or read data.
- `bus_rdata`  in  32  read word.

## Operation
- Lane map is little-endian. Byte k = `addr[1:0]`. Halfword occupies lanes {2h+1, 2h}, where h = `addr[1]`.
- Store lanes and enables:
  - W: data unchanged, BE 1111.
  - H: `{2{wdata[15:0]}}`, BE 0011 (h=0) or 1100 (h=1).
  - B: `{4{wdata[7:0]}}`, BE one-hot at k.
- Load extension: H/B sign-extend the selected lane to 32 bits; HU/BU zero-extend it.
- Errors, detected in IDLE; no bus command is issued:
  - W with `addr[1:0]` ≠ 0.
  - H/HU with `addr[0]` = 1.
  - op > 4.
  - HU/BU with `cpu_we` = 1.
- FSM states: IDLE, REQ, RESP, DONE, ERR.
  - IDLE: `cpu_req` & legal → REQ, registering addr, we, be, wdata and op. `cpu_req` & illegal → ERR.
  - REQ: `bus_req` = 1. `bus_gnt` → RESP.
  - RESP: `bus_rvalid` → DONE; capture the extended `bus_rdata` into `cpu_rdata` (loads only; stores leave it unchanged).
  - REQ or RESP, when the timeout counter reaches `TIMEOUT` → ERR, dropping `bus_req` at once.
  - DONE → IDLE unconditionally.
  - ERR → IDLE unconditionally.
- Outputs by state:
  - DONE: `cpu_done` = 1.
  - ERR: `cpu_done` = 1 and `cpu_err` = 1.
- `cpu_stall` = `cpu_req` & state ∉ {DONE, ERR}. Combinational.
- Timeout counter: 8 bits, cleared on entering REQ, increments every cycle in REQ/RESP.

## Timing
- Reset values: state IDLE; every output 0, including `cpu_rdata` and `bus_*`; counter 0.
- Reset asserted mid-transaction aborts immediately. `bus_req` falls asynchronously. A later `bus_rvalid` is ignored.
- `bus_addr`, `bus_we`, `bus_be` and `bus_wdata` are registered and stable throughout REQ. `bus_req` never falls without `bus_gnt`, except on timeout or reset.
- Best-case latency, with `bus_gnt` in the first REQ cycle and `bus_rvalid` in the first RESP cycle:
  - cycle 0: IDLE samples `cpu_req`.
  - cycle 1: REQ.
  - cycle 2: RESP.
  - cycle 3: DONE.
- Stall is high in cycles 0–2 and low in cycle 3.
- Error path: IDLE sees an illegal request in cycle 0; ERR in cycle 1.
- The next request is sampled no earlier than the IDLE cycle that follows DONE/ERR. Back-to-back accesses therefore cost at least 4 cycles each.
- `bus_rvalid` outside RESP is ignored; this includes a stray response after a timeout.
- `bus_rvalid` in the same cycle the timeout fires: rvalid wins → DONE.

## Structure
- The shared encode define header holds:
  - `cpu_op` codes.
  - FSM state encodings.
  - BE width 4 and data width 32.
- One combinational sub-module, `dm_lane_align`: (op, we, laddr, wdata, rdata) → (be, wdata_rep, rdata_ext, misalign). It is reused by any future cache fill path. The FSM, registers and counter stay in the top module.

## Test plan
- SB, `addr` 0x1003, `wdata` 0xA5 → `bus_addr` 0x1000, `bus_be` 1000, `bus_wdata` 0xA5A5A5A5. Ack in the first RESP cycle → `cpu_done` in cycle 3, stall high for 3 cycles.
- LH, `addr` 0x2002, `bus_rdata` 0x8001_1234 → `cpu_rdata` 0xFFFF8001. Repeat as LHU → 0x00008001.
- LB at `addr[1:0]` = 1, `bus_rdata` 0x0000_F000 → `cpu_rdata` 0xFFFFFFF0. Repeat as LBU → 0x000000F0.
- LW at 0x3002 → ERR in cycle 1 with `cpu_done` = 1 and `cpu_err` = 1; `bus_req` never rises.
- `bus_gnt` held low, `TIMEOUT` = 8 → `bus_req` high exactly 8 cycles, then ERR. A later stray `bus_rvalid` is ignored.
- `rst_n` pulsed low while in RESP → all outputs 0 immediately; the next `cpu_req` completes normally.
